// File: rtl/counters_pkg.sv
// Shared helpers for the counters library: count-width derivation and
// the wrap value (MAX-1) used by the modulus counters.
package counters_pkg;

    // Width needed to hold counts 0..max-1.
    function automatic int cnt_width(input int max);
        return $clog2(max);
    endfunction

    // Value a modulo-max counter wraps to or reloads from; callers cast to W bits.
    function automatic int wrap_value(input int max);
        return max - 1;
    endfunction

endpackage

// File: rtl/modulus_down_counter.sv
// Modulo-MAX down-counter with clamped parallel load and terminal-count flag.
// Optional halt-at-zero mode enabled by defining MODULUS_DOWN_COUNTER_ONESHOT_EN.
module modulus_down_counter
    import counters_pkg::*;
#(
    parameter int MAX = 53,
    localparam int W = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
`ifdef MODULUS_DOWN_COUNTER_ONESHOT_EN
    input  logic         oneshot,
    output logic         done,
`endif
    output logic [W-1:0] Q,
    output logic         tc
);

    localparam logic [W-1:0] WRAP = W'(wrap_value(MAX));

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

`ifdef MODULUS_DOWN_COUNTER_ONESHOT_EN
    logic done_q;
    logic done_d;
`endif

    // Zero test comes before the decrement, so no underflow is ever stored.
    always_comb begin
        count_d = count_q;
`ifdef MODULUS_DOWN_COUNTER_ONESHOT_EN
        done_d  = done_q;
`endif
        if (load) begin
            count_d = (load_value > WRAP) ? WRAP : load_value;
`ifdef MODULUS_DOWN_COUNTER_ONESHOT_EN
            done_d  = 1'b0;
`endif
        end else if (!enable_n) begin
            if (count_q == '0) begin
`ifdef MODULUS_DOWN_COUNTER_ONESHOT_EN
                if (oneshot) begin
                    count_d = '0;
                    done_d  = 1'b1;
                end else begin
                    count_d = WRAP;
                end
`else
                count_d = WRAP;
`endif
            end else begin
                count_d = count_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= WRAP;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef MODULUS_DOWN_COUNTER_ONESHOT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`endif

    assign Q  = count_q;
    assign tc = (count_q == '0) && !enable_n;

endmodule
